// File: rtl/par_chk_acc.sv
// par_chk_acc: serial frame parity checker with optional sticky error flag and saturating error counter.
// Ports: CLK/RST (sync active-low) clock and reset; PAR_MODE 0 none, 1 even, 2 odd, 3 mark, 4 space, 5-7 none;
//   frame_start/data_bit_vld/par_bit_vld/sampled_bit carry the serial frame, LSB first; err_clr clears flag and counter;
//   P_DATA assembled data, par_done/par_err/len_err one-cycle result pulses;
//   par_err_sticky/err_cnt are built only with PAR_CHK_ERR_CNT_EN defined, otherwise tied to 0.
module par_chk_acc #(
  parameter int DATA_WD = 8,
  parameter int CNT_WD = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [2:0]         PAR_MODE,
  input  logic               frame_start,
  input  logic               data_bit_vld,
  input  logic               par_bit_vld,
  input  logic               sampled_bit,
  input  logic               err_clr,
  output logic [DATA_WD-1:0] P_DATA,
  output logic               par_done,
  output logic               par_err,
  output logic               len_err,
  output logic               par_err_sticky,
  output logic [CNT_WD-1:0]  err_cnt
);
  localparam int BW = $clog2(DATA_WD);
  typedef enum logic [1:0] {IDLE, DATA, WAIT_PAR} state_t;
  state_t r_state, w_next;
  logic [2:0] r_mode;
  logic [BW-1:0] r_cnt;
  logic r_acc;
  logic w_none, w_exp, w_shift, w_last, w_done, w_perr, w_lerr;
  assign w_none = (r_mode == 3'd0) || (r_mode > 3'd4);
  assign w_exp = (r_mode == 3'd1) ? r_acc : (r_mode == 3'd2) ? ~r_acc : (r_mode == 3'd3);
  // a parity bit in DATA wins over a coincident data bit, so no shift then
  assign w_shift = (r_state == DATA) && data_bit_vld && !par_bit_vld && !frame_start;
  assign w_last = w_shift && (r_cnt == BW'(DATA_WD - 1));
  always_ff @(posedge CLK)
    if (!RST) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    w_perr = 1'b0;
    w_lerr = 1'b0;
    if (frame_start) w_next = DATA;
    else if (r_state == DATA && par_bit_vld) begin
      w_next = IDLE;
      w_done = 1'b1;
      w_lerr = 1'b1;
    end else if (w_last) begin
      w_next = w_none ? IDLE : WAIT_PAR;
      w_done = w_none;
    end else if (r_state == WAIT_PAR && par_bit_vld) begin
      w_next = IDLE;
      w_done = 1'b1;
      w_perr = sampled_bit ^ w_exp;
    end
  end
  always_ff @(posedge CLK)
    if (!RST) begin
      r_mode <= 3'd0;
      r_cnt <= '0;
      r_acc <= 1'b0;
      P_DATA <= '0;
      par_done <= 1'b0;
      par_err <= 1'b0;
      len_err <= 1'b0;
    end else begin
      par_done <= w_done;
      par_err <= w_perr;
      len_err <= w_lerr;
      if (frame_start) begin
        r_mode <= PAR_MODE;
        r_cnt <= '0;
        r_acc <= 1'b0;
        P_DATA <= '0;
      end else if (w_shift) begin
        r_acc <= r_acc ^ sampled_bit;
        P_DATA[r_cnt] <= sampled_bit;
        r_cnt <= r_cnt + 1'b1;
      end
    end
`ifdef PAR_CHK_ERR_CNT_EN
  // an error pulse coincident with err_clr counts as the first event after the clear
  always_ff @(posedge CLK)
    if (!RST) begin
      par_err_sticky <= 1'b0;
      err_cnt <= '0;
    end else if (err_clr) begin
      par_err_sticky <= par_err;
      err_cnt <= CNT_WD'(par_err | len_err);
    end else begin
      par_err_sticky <= par_err_sticky | par_err;
      if ((par_err | len_err) && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
    end
`else
  logic w_unused;
  assign w_unused = err_clr;
  assign par_err_sticky = 1'b0;
  assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_par_chk_acc.sv
// tb_par_chk_acc: directed scoreboard bench for par_chk_acc (DATA_WD=8, CNT_WD=2).
module tb_par_chk_acc;
`ifdef PAR_CHK_ERR_CNT_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif
  logic CLK = 1'b0, RST, frame_start, data_bit_vld, par_bit_vld, sampled_bit, err_clr;
  logic [2:0] PAR_MODE;
  logic [7:0] P_DATA;
  logic par_done, par_err, len_err, par_err_sticky;
  logic [1:0] err_cnt;
  typedef struct {
    logic [7:0] d;
    logic pe;
    logic le;
    int due;
  } exp_t;
  exp_t q[$];
  int n_vec = 0, n_err = 0, cyc = 0;
  logic [1:0] m_cnt = 2'd0;
  logic m_st = 1'b0, ev = 1'b0, pe = 1'b0;
  par_chk_acc #(.DATA_WD(8), .CNT_WD(2)) dut (
    .CLK(CLK), .RST(RST), .PAR_MODE(PAR_MODE), .frame_start(frame_start),
    .data_bit_vld(data_bit_vld), .par_bit_vld(par_bit_vld), .sampled_bit(sampled_bit),
    .err_clr(err_clr), .P_DATA(P_DATA), .par_done(par_done), .par_err(par_err),
    .len_err(len_err), .par_err_sticky(par_err_sticky), .err_cnt(err_cnt)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    logic clr, rst;
    exp_t e;
    clr = err_clr;
    rst = RST;
    @(posedge CLK);
    #1;
    cyc++;
    if (!rst) begin
      m_cnt = 2'd0;
      m_st = 1'b0;
    end else if (EN) begin
      if (clr) begin
        m_cnt = {1'b0, ev};
        m_st = pe;
      end else begin
        if (ev && m_cnt != 2'd3) m_cnt = m_cnt + 2'd1;
        m_st = m_st | pe;
      end
    end
    ev = 1'b0;
    pe = 1'b0;
    if (par_done === 1'b1) begin
      if (q.size() == 0) chk("spurious_done", par_done, 0);
      else begin
        e = q.pop_front();
        chk("done_cycle", cyc, e.due);
        chk("p_data", P_DATA, e.d);
        chk("par_err", par_err, e.pe);
        chk("len_err", len_err, e.le);
        ev = e.pe | e.le;
        pe = e.pe;
      end
    end else begin
      chk("par_err_no_done", par_err, 0);
      chk("len_err_no_done", len_err, 0);
      if (q.size() > 0 && q[0].due <= cyc) begin
        chk("missing_done", par_done, 1);
        void'(q.pop_front());
      end
    end
    chk("sticky", par_err_sticky, m_st);
    chk("err_cnt", err_cnt, m_cnt);
  endtask
  task automatic idle(input int n);
    repeat (n) tick();
  endtask
  task automatic frame(input logic [2:0] m, input logic [7:0] d, input int n, input bit sp, input logic p, input bit both);
    logic [7:0] md;
    logic acc, ex, none;
    exp_t e;
    md = 8'h00;
    for (int i = 0; i < n; i++) md[i] = d[i];
    acc = ^md;
    ex = (m == 3'd1) ? acc : (m == 3'd2) ? ~acc : (m == 3'd3);
    none = (m == 3'd0) || (m > 3'd4);
    frame_start = 1'b1;
    PAR_MODE = m;
    tick();
    frame_start = 1'b0;
    PAR_MODE = 3'd7;
    for (int i = 0; i < n; i++) begin
      data_bit_vld = 1'b1;
      sampled_bit = d[i];
      if (i == 7 && none) begin
        e = '{d: md, pe: 1'b0, le: 1'b0, due: cyc + 1};
        q.push_back(e);
      end
      tick();
    end
    data_bit_vld = 1'b0;
    if (sp) begin
      par_bit_vld = 1'b1;
      sampled_bit = p;
      data_bit_vld = both;
      if (n < 8) begin
        e = '{d: md, pe: 1'b0, le: 1'b1, due: cyc + 1};
        q.push_back(e);
      end else if (!none) begin
        e = '{d: md, pe: p ^ ex, le: 1'b0, due: cyc + 1};
        q.push_back(e);
      end
      tick();
      par_bit_vld = 1'b0;
      data_bit_vld = 1'b0;
    end
    sampled_bit = 1'b0;
  endtask
  initial begin
    RST = 1'b0;
    PAR_MODE = 3'd0;
    frame_start = 1'b0;
    data_bit_vld = 1'b0;
    par_bit_vld = 1'b0;
    sampled_bit = 1'b0;
    err_clr = 1'b0;
    idle(2);
    chk("rst_p_data", P_DATA, 0);
    chk("rst_done", par_done, 0);
    RST = 1'b1;
    idle(1);
    frame(3'd1, 8'hA5, 8, 1'b1, 1'b0, 1'b0);
    idle(2);
    frame(3'd2, 8'hA5, 8, 1'b1, 1'b0, 1'b0);
    idle(2);
    frame(3'd0, 8'h3C, 8, 1'b1, 1'b1, 1'b0);
    idle(2);
    frame(3'd5, 8'h81, 8, 1'b0, 1'b0, 1'b0);
    idle(2);
    frame(3'd3, 8'h15, 5, 1'b1, 1'b1, 1'b0);
    idle(2);
    frame(3'd1, 8'h07, 3, 1'b1, 1'b1, 1'b1);
    idle(2);
    frame(3'd4, 8'hFF, 4, 1'b0, 1'b0, 1'b0);
    frame(3'd4, 8'h0F, 8, 1'b1, 1'b0, 1'b0);
    idle(2);
    frame(3'd2, 8'h01, 8, 1'b1, 1'b0, 1'b0);
    idle(3);
    chk("p_data_hold", P_DATA, 8'h01);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    idle(1);
    repeat (4) begin
      frame(3'd3, 8'h00, 8, 1'b1, 1'b0, 1'b0);
      idle(1);
    end
    frame(3'd3, 8'h00, 8, 1'b1, 1'b0, 1'b0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    idle(2);
    frame(3'd1, 8'hFF, 3, 1'b0, 1'b0, 1'b0);
    RST = 1'b0;
    tick();
    RST = 1'b1;
    chk("rst_mid_p_data", P_DATA, 0);
    data_bit_vld = 1'b1;
    sampled_bit = 1'b1;
    idle(2);
    data_bit_vld = 1'b0;
    par_bit_vld = 1'b1;
    tick();
    par_bit_vld = 1'b0;
    sampled_bit = 1'b0;
    idle(3);
    chk("idle_ignore_p_data", P_DATA, 0);
    for (int i = 0; i < 5 && q.size() > 0; i++) tick();
    chk("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
